// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline boundary register with valid/ready handshake, one-entry skid
// buffer, flush (bubble insertion) and a saturating stall-cycle counter.
module ex_mem_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  reg_write_enable_in,
    input  logic                  mem_write_enable_in,
    input  logic                  mem_read_enable_in,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     store_data_in,
    input  logic [REG_ADDR_W-1:0] dest_reg_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  reg_write_enable_out,
    output logic                  mem_write_enable_out,
    output logic                  mem_read_enable_out,
    output logic [DATA_W-1:0]     alu_result_out,
    output logic [DATA_W-1:0]     store_data_out,
    output logic [REG_ADDR_W-1:0] dest_reg_out,
    output logic [CNT_W-1:0]      stall_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              main_ctrl_q, main_ctrl_d;
    logic [2:0]              skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]       main_alu_q, main_alu_d;
    logic [DATA_W-1:0]       main_store_q, main_store_d;
    logic [REG_ADDR_W-1:0]   main_dest_q, main_dest_d;
    logic [DATA_W-1:0]       skid_alu_q, skid_alu_d;
    logic [DATA_W-1:0]       skid_store_q, skid_store_d;
    logic [REG_ADDR_W-1:0]   skid_dest_q, skid_dest_d;
    logic [CNT_W-1:0]        stall_q, stall_d;
    logic [2:0]              ctrl_in;
    logic                    acc;
    logic                    dep;

    // in_ready depends on the state register only, so out_ready never reaches it.
    assign in_ready  = (state_q == ST_EMPTY) || (state_q == ST_FULL);
    assign out_valid = (state_q == ST_FULL) || (state_q == ST_SKID);
    assign acc       = in_valid & in_ready;
    assign dep       = out_valid & out_ready;
    assign ctrl_in   = {reg_write_enable_in, mem_write_enable_in, mem_read_enable_in};

    always_comb begin
        state_d      = state_q;
        main_ctrl_d  = main_ctrl_q;
        main_alu_d   = main_alu_q;
        main_store_d = main_store_q;
        main_dest_d  = main_dest_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_alu_d   = skid_alu_q;
        skid_store_d = skid_store_q;
        skid_dest_d  = skid_dest_q;

        if (flush) begin
            // Payloads keep their last value; only the enables are dropped.
            state_d     = ST_EMPTY;
            main_ctrl_d = 3'b000;
            skid_ctrl_d = 3'b000;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        main_ctrl_d  = ctrl_in;
                        main_alu_d   = alu_result_in;
                        main_store_d = store_data_in;
                        main_dest_d  = dest_reg_in;
                        state_d      = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (acc && dep) begin
                        main_ctrl_d  = ctrl_in;
                        main_alu_d   = alu_result_in;
                        main_store_d = store_data_in;
                        main_dest_d  = dest_reg_in;
                    end else if (acc) begin
                        skid_ctrl_d  = ctrl_in;
                        skid_alu_d   = alu_result_in;
                        skid_store_d = store_data_in;
                        skid_dest_d  = dest_reg_in;
                        state_d      = ST_SKID;
                    end else if (dep) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (dep) begin
                        main_ctrl_d  = skid_ctrl_q;
                        main_alu_d   = skid_alu_q;
                        main_store_d = skid_store_q;
                        main_dest_d  = skid_dest_q;
                        state_d      = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_EMPTY;
            main_ctrl_q  <= 3'b000;
            main_alu_q   <= '0;
            main_store_q <= '0;
            main_dest_q  <= '0;
            skid_ctrl_q  <= 3'b000;
            skid_alu_q   <= '0;
            skid_store_q <= '0;
            skid_dest_q  <= '0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            main_ctrl_q  <= main_ctrl_d;
            main_alu_q   <= main_alu_d;
            main_store_q <= main_store_d;
            main_dest_q  <= main_dest_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_alu_q   <= skid_alu_d;
            skid_store_q <= skid_store_d;
            skid_dest_q  <= skid_dest_d;
            stall_q      <= stall_d;
        end
    end

    assign reg_write_enable_out = main_ctrl_q[2] & out_valid;
    assign mem_write_enable_out = main_ctrl_q[1] & out_valid;
    assign mem_read_enable_out  = main_ctrl_q[0] & out_valid;
    assign alu_result_out       = main_alu_q;
    assign store_data_out       = main_store_q;
    assign dest_reg_out         = main_dest_q;
    assign stall_count          = stall_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg: a FIFO model of accepted entries is
// checked every cycle against the handshake, payload, enables and stall counter.
module tb_ex_mem_pipe_reg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 4;
    localparam int CNT_W      = 4;

    logic                  clk;
    logic                  reset;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic                  reg_write_enable_in;
    logic                  mem_write_enable_in;
    logic                  mem_read_enable_in;
    logic [DATA_W-1:0]     alu_result_in;
    logic [DATA_W-1:0]     store_data_in;
    logic [REG_ADDR_W-1:0] dest_reg_in;
    logic                  out_valid;
    logic                  out_ready;
    logic                  reg_write_enable_out;
    logic                  mem_write_enable_out;
    logic                  mem_read_enable_out;
    logic [DATA_W-1:0]     alu_result_out;
    logic [DATA_W-1:0]     store_data_out;
    logic [REG_ADDR_W-1:0] dest_reg_out;
    logic [CNT_W-1:0]      stall_count;

    ex_mem_pipe_reg #(
        .DATA_W    (DATA_W),
        .REG_ADDR_W(REG_ADDR_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .flush               (flush),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .reg_write_enable_in (reg_write_enable_in),
        .mem_write_enable_in (mem_write_enable_in),
        .mem_read_enable_in  (mem_read_enable_in),
        .alu_result_in       (alu_result_in),
        .store_data_in       (store_data_in),
        .dest_reg_in         (dest_reg_in),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .reg_write_enable_out(reg_write_enable_out),
        .mem_write_enable_out(mem_write_enable_out),
        .mem_read_enable_out (mem_read_enable_out),
        .alu_result_out      (alu_result_out),
        .store_data_out      (store_data_out),
        .dest_reg_out        (dest_reg_out),
        .stall_count         (stall_count)
    );

    typedef struct packed {
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     st;
        logic [REG_ADDR_W-1:0] dst;
        logic [2:0]            en;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] got_log[$];
    int          total_cnt = 0;
    int          bad_cnt   = 0;
    int          stall_m   = 0;
    int          sz_m;
    txn_t        front_m;
    txn_t        cur_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a);
        logic [2:0] en_v;
        en_v                = 3'($urandom_range(7, 0));
        in_valid            = 1'b1;
        alu_result_in       = a;
        store_data_in       = a ^ 32'hFFFF_0000;
        dest_reg_in         = a[7:4];
        reg_write_enable_in = en_v[2];
        mem_write_enable_in = en_v[1];
        mem_read_enable_in  = en_v[0];
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Model: entries are accepted when fewer than two are held (registered ready),
    // delivered from the front, and all discarded by flush.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            stall_m = 0;
        end else begin
            sz_m = exp_q.size();
            check("in_ready", 64'(in_ready), 64'(sz_m < 2));
            check("out_valid", 64'(out_valid), 64'(sz_m > 0));
            check("stall_count", 64'(stall_count), 64'(stall_m));
            if (sz_m > 0) begin
                front_m = exp_q[0];
                check("alu_out", 64'(alu_result_out), 64'(front_m.alu));
                check("store_out", 64'(store_data_out), 64'(front_m.st));
                check("dest_out", 64'(dest_reg_out), 64'(front_m.dst));
                check("enables_out",
                      64'({reg_write_enable_out, mem_write_enable_out, mem_read_enable_out}),
                      64'(front_m.en));
                if (out_ready) begin
                    got_log.push_back(alu_result_out);
                    void'(exp_q.pop_front());
                end else if (stall_m != (1 << CNT_W) - 1) begin
                    stall_m++;
                end
            end else begin
                check("enables_idle",
                      64'({reg_write_enable_out, mem_write_enable_out, mem_read_enable_out}),
                      64'd0);
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && sz_m < 2) begin
                cur_m.alu = alu_result_in;
                cur_m.st  = store_data_in;
                cur_m.dst = dest_reg_in;
                cur_m.en  = {reg_write_enable_in, mem_write_enable_in, mem_read_enable_in};
                exp_q.push_back(cur_m);
            end
        end
    end

    initial begin
        logic [31:0] stream_vals[4];
        logic [31:0] bp_vals[3];
        int          seen;
        stream_vals = '{32'h10, 32'h20, 32'h30, 32'h40};
        bp_vals     = '{32'hA, 32'hB, 32'hC};

        reset = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        reg_write_enable_in = 1'b0;
        mem_write_enable_in = 1'b0;
        mem_read_enable_in = 1'b0;
        alu_result_in = '0;
        store_data_in = '0;
        dest_reg_in = '0;
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_alu", 64'(alu_result_out), 64'd0);
        step();
        reset = 1'b1;

        // Streaming at full throughput
        got_log.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(stream_vals[i]);
            step();
            check("stream_latency", 64'(alu_result_out), 64'(stream_vals[i]));
        end
        in_valid = 1'b0;
        wait_drain();
        check("stream_count", 64'(got_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < got_log.size(); i++)
            check("stream_order", 64'(got_log[i]), 64'(stream_vals[i]));
        check("stream_stall", 64'(stall_count), 64'd0);

        // Backpressure into the skid entry, third input held off
        do_reset();
        got_log.delete();
        out_ready = 1'b0;
        drive(32'hA);
        step();
        drive(32'hB);
        step();
        check("skid_in_ready", 64'(in_ready), 64'd0);
        drive(32'hC);
        step();
        step();
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        wait_drain();
        check("bp_stall", 64'(stall_count), 64'd3);
        check("bp_count", 64'(got_log.size()), 64'd3);
        for (int i = 0; i < 3 && i < got_log.size(); i++)
            check("bp_order", 64'(got_log[i]), 64'(bp_vals[i]));

        // Flush while in SKID with a valid input
        got_log.delete();
        out_ready = 1'b0;
        drive(32'hE);
        step();
        drive(32'hF);
        step();
        drive(32'hD);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_enables",
              64'({reg_write_enable_out, mem_write_enable_out, mem_read_enable_out}), 64'd0);
        // Flush in FULL with in_ready=1: input dropped, delivered entry kept
        out_ready = 1'b1;
        drive(32'h77);
        step();
        drive(32'h88);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_full_valid", 64'(out_valid), 64'd0);
        repeat (3) step();
        seen = 0;
        foreach (got_log[i]) if (got_log[i] == 32'hD || got_log[i] == 32'h88) seen++;
        check("flushed_never_seen", 64'(seen), 64'd0);
        check("flush_dep_delivered", 64'(got_log.size()), 64'd1);

        // Enables gated while nothing is valid
        in_valid = 1'b0;
        reg_write_enable_in = 1'b1;
        mem_write_enable_in = 1'b1;
        repeat (3) step();
        check("gate_rwe", 64'(reg_write_enable_out), 64'd0);
        check("gate_mwe", 64'(mem_write_enable_out), 64'd0);

        // Stall counter saturation
        do_reset();
        out_ready = 1'b0;
        drive(32'h55);
        step();
        in_valid = 1'b0;
        repeat (20) step();
        check("stall_saturate", 64'(stall_count), 64'd15);
        out_ready = 1'b1;
        wait_drain();
        check("stall_kept_after_drain", 64'(stall_count), 64'd15);

        // Asynchronous reset mid-stream with SKID occupied
        out_ready = 1'b0;
        drive(32'hA1);
        step();
        drive(32'hA2);
        step();
        drive(32'hA3);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_enables",
              64'({reg_write_enable_out, mem_write_enable_out, mem_read_enable_out}), 64'd0);
        check("arst_alu", 64'(alu_result_out), 64'd0);
        check("arst_store", 64'(store_data_out), 64'd0);
        check("arst_dest", 64'(dest_reg_out), 64'd0);
        check("arst_stall", 64'(stall_count), 64'd0);
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        got_log.delete();
        out_ready = 1'b1;
        drive(32'h99);
        step();
        in_valid = 1'b0;
        check("post_reset_load", 64'(alu_result_out), 64'h99);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
